// File: rtl/axi_ar_route_decoder.sv
// axi_ar_route_decoder: routes one AR request to a decoded initiator port or raises DECERR; `AXI_AR_DEST_LOCK_EN adds drain-before-port-switch ordering
module axi_ar_route_decoder #(
  parameter int N_INIT_PORT = 4,
  parameter int AXI_ADDR_W  = 32,
  parameter int AXI_ID_IN   = 16,
  parameter int AXI_USER_W  = 6
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [AXI_ADDR_W-1:0]             araddr_i,
  input  logic [AXI_ID_IN-1:0]              arid_i,
  input  logic [7:0]                        arlen_i,
  input  logic [AXI_USER_W-1:0]             aruser_i,
  input  logic                              arvalid_i,
  output logic                              arready_o,
  input  logic [N_INIT_PORT*AXI_ADDR_W-1:0] start_addr_i,
  input  logic [N_INIT_PORT*AXI_ADDR_W-1:0] end_addr_i,
  input  logic [N_INIT_PORT-1:0]            enable_region_i,
  output logic [AXI_ADDR_W-1:0]             araddr_o,
  output logic [AXI_ID_IN-1:0]              arid_o,
  output logic [7:0]                        arlen_o,
  output logic [AXI_USER_W-1:0]             aruser_o,
  output logic [N_INIT_PORT-1:0]            arvalid_o,
  input  logic [N_INIT_PORT-1:0]            arready_i,
  output logic                              incr_req_o,
  input  logic                              full_counter_i,
  input  logic                              outstanding_trans_i,
  output logic                              error_req_o,
  input  logic                              error_gnt_i,
  output logic [7:0]                        error_len_o,
  output logic [AXI_ID_IN-1:0]              error_id_o,
  output logic [AXI_USER_W-1:0]             error_user_o,
  output logic                              sample_ardata_info_o
);
  localparam int IW = N_INIT_PORT > 1 ? $clog2(N_INIT_PORT) : 1;
  typedef enum logic [1:0] {IDLE, FWD, DRAIN, ERR} state_t;
  state_t                r_state, w_next;
  logic [AXI_ADDR_W-1:0] r_addr;
  logic [AXI_ID_IN-1:0]  r_id;
  logic [7:0]            r_len;
  logic [AXI_USER_W-1:0] r_user;
  logic [IW-1:0]         r_dest, w_dest;
  logic                  w_any, w_acc, w_hs, w_lock;
  always_comb begin
    w_any  = 1'b0;
    w_dest = '0;
    for (int i = N_INIT_PORT - 1; i >= 0; i--)
      if (enable_region_i[i] && araddr_i >= start_addr_i[i*AXI_ADDR_W +: AXI_ADDR_W] &&
          araddr_i <= end_addr_i[i*AXI_ADDR_W +: AXI_ADDR_W]) begin
        w_any  = 1'b1;
        w_dest = IW'(i);
      end
  end
  assign arready_o = rst_n & (r_state == IDLE) & ~full_counter_i;
  assign w_acc     = arvalid_i & arready_o;
  assign w_hs      = (r_state == FWD) & arready_i[r_dest];
`ifdef AXI_AR_DEST_LOCK_EN
  logic [IW-1:0] r_last;
  assign w_lock = (w_dest != r_last) & outstanding_trans_i;
  always_ff @(posedge clk)
    if (!rst_n) r_last <= '0;
    else if (w_hs) r_last <= r_dest;
`else
  assign w_lock = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = !w_acc ? IDLE : !w_any ? ERR : w_lock ? DRAIN : FWD;
      FWD:     w_next = w_hs ? IDLE : FWD;
      DRAIN:   w_next = outstanding_trans_i ? DRAIN : FWD;
      ERR:     w_next = error_gnt_i ? IDLE : ERR;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_user  <= '0;
      r_dest  <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_addr <= araddr_i;
        r_id   <= arid_i;
        r_len  <= arlen_i;
        r_user <= aruser_i;
        r_dest <= w_dest;
      end
    end
  assign arvalid_o            = N_INIT_PORT'(r_state == FWD) << r_dest;
  assign incr_req_o           = w_hs;
  assign error_req_o          = r_state == ERR;
  assign sample_ardata_info_o = w_acc & ~w_any;
  assign araddr_o             = r_addr;
  assign arid_o               = r_id;
  assign arlen_o              = r_len;
  assign aruser_o             = r_user;
  assign error_len_o          = r_len;
  assign error_id_o           = r_id;
  assign error_user_o         = r_user;
endmodule

// File: tb/tb_axi_ar_route_decoder.sv
// tb_axi_ar_route_decoder: directed test-plan scenarios plus random traffic checked against a transaction-level model
module tb_axi_ar_route_decoder;
  localparam int N = 4, AW = 32, IDW = 16, UW = 6;
`ifdef AXI_AR_DEST_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif
  localparam int K_FWD = 0, K_DRN = 1, K_ERR = 2;
  logic clk = 1'b0, rst_n;
  logic [AW-1:0] araddr_i, araddr_o;
  logic [IDW-1:0] arid_i, arid_o, error_id_o;
  logic [7:0] arlen_i, arlen_o, error_len_o;
  logic [UW-1:0] aruser_i, aruser_o, error_user_o;
  logic arvalid_i, arready_o, incr_req_o, full_counter_i, outstanding_trans_i;
  logic error_req_o, error_gnt_i, sample_ardata_info_o;
  logic [N*AW-1:0] start_addr_i, end_addr_i;
  logic [N-1:0] enable_region_i, arvalid_o, arready_i;
  logic [AW-1:0] s_a [N];
  logic [AW-1:0] e_a [N];
  for (genvar g = 0; g < N; g++) begin : g_pack
    assign start_addr_i[g*AW +: AW] = s_a[g];
    assign end_addr_i[g*AW +: AW]   = e_a[g];
  end
  axi_ar_route_decoder #(.N_INIT_PORT(N), .AXI_ADDR_W(AW), .AXI_ID_IN(IDW), .AXI_USER_W(UW)) dut (
    .clk(clk), .rst_n(rst_n), .araddr_i(araddr_i), .arid_i(arid_i), .arlen_i(arlen_i),
    .aruser_i(aruser_i), .arvalid_i(arvalid_i), .arready_o(arready_o),
    .start_addr_i(start_addr_i), .end_addr_i(end_addr_i), .enable_region_i(enable_region_i),
    .araddr_o(araddr_o), .arid_o(arid_o), .arlen_o(arlen_o), .aruser_o(aruser_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i), .incr_req_o(incr_req_o),
    .full_counter_i(full_counter_i), .outstanding_trans_i(outstanding_trans_i),
    .error_req_o(error_req_o), .error_gnt_i(error_gnt_i), .error_len_o(error_len_o),
    .error_id_o(error_id_o), .error_user_o(error_user_o),
    .sample_ardata_info_o(sample_ardata_info_o));
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  bit m_busy;
  int m_kind, m_dest, m_last;
  logic [AW-1:0] m_addr;
  logic [IDW-1:0] m_id;
  logic [7:0] m_len;
  logic [UW-1:0] m_user;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int ref_dest();
    for (int k = 0; k < N; k++)
      if (enable_region_i[k] && araddr_i >= s_a[k] && araddr_i <= e_a[k]) return k;
    return -1;
  endfunction
  task automatic model_reset();
    m_busy = 0; m_kind = K_FWD; m_dest = 0; m_last = 0;
    m_addr = '0; m_id = '0; m_len = '0; m_user = '0;
  endtask
  task automatic cyc();
    int d;
    bit rdy, acc, inc;
    logic [N-1:0] ev;
    #1;
    d   = ref_dest();
    rdy = rst_n && !m_busy && !full_counter_i;
    acc = arvalid_i && rdy;
    ev  = (m_busy && m_kind == K_FWD) ? N'(1 << m_dest) : '0;
    inc = (ev != 0) && arready_i[m_dest];
    chk("arready", arready_o, rdy);
    chk("arvalid", arvalid_o, ev);
    chk("incr_req", incr_req_o, inc);
    chk("sample", sample_ardata_info_o, acc && d < 0);
    chk("error_req", error_req_o, m_busy && m_kind == K_ERR);
    chk("araddr", araddr_o, m_addr);
    chk("arid", arid_o, m_id);
    chk("arlen", arlen_o, m_len);
    chk("aruser", aruser_o, m_user);
    chk("error_len", error_len_o, m_len);
    chk("error_id", error_id_o, m_id);
    chk("error_user", error_user_o, m_user);
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (!m_busy) begin
      if (acc) begin
        m_busy = 1; m_addr = araddr_i; m_id = arid_i; m_len = arlen_i; m_user = aruser_i;
        m_dest = d;
        m_kind = d < 0 ? K_ERR : (LOCK && d != m_last && outstanding_trans_i) ? K_DRN : K_FWD;
      end
    end else if (m_kind == K_FWD) begin
      if (inc) begin m_busy = 0; m_last = m_dest; end
    end else if (m_kind == K_DRN) begin
      if (!outstanding_trans_i) m_kind = K_FWD;
    end else if (error_gnt_i) m_busy = 0;
    #1;
  endtask
  task automatic set_ar(input logic [AW-1:0] a, input logic [IDW-1:0] id, input logic [7:0] len, input logic [UW-1:0] u);
    araddr_i = a; arid_i = id; arlen_i = len; aruser_i = u; arvalid_i = 1'b1;
  endtask
  task automatic regions_off();
    for (int k = 0; k < N; k++) begin s_a[k] = '0; e_a[k] = '0; end
    enable_region_i = '0;
  endtask
  initial begin
    rst_n = 0; arvalid_i = 0; araddr_i = '0; arid_i = '0; arlen_i = '0; aruser_i = '0;
    arready_i = '0; full_counter_i = 0; outstanding_trans_i = 0; error_gnt_i = 0;
    regions_off();
    repeat (2) @(posedge clk);
    #1; model_reset();
    cyc();
    rst_n = 1; cyc();
    // simple hit on port 0, held until ready
    s_a[0] = 32'h0000_0000; e_a[0] = 32'h0FFF_FFFF; enable_region_i = 4'b0001;
    set_ar(32'h0000_1000, 16'h5, 8'd3, 6'h11); cyc();
    arvalid_i = 0; cyc(); cyc();
    chk("tp1_valid", arvalid_o, 4'b0001);
    arready_i = 4'b0001; cyc();
    arready_i = 4'b0000; cyc();
    // decode miss -> DECERR
    set_ar(32'h8000_0000, 16'h9, 8'd7, 6'h22); cyc();
    arvalid_i = 0; repeat (3) cyc();
    chk("tp2_errlen", error_len_o, 8'd7);
    error_gnt_i = 1; cyc();
    error_gnt_i = 0; cyc();
    // port switch while bursts outstanding
    s_a[2] = 32'h1000_0000; e_a[2] = 32'h1FFF_FFFF; enable_region_i = 4'b0101;
    outstanding_trans_i = 1; arready_i = 4'b1111;
    set_ar(32'h0000_0100, 16'h1, 8'd0, 6'h01); cyc();
    arvalid_i = 0; arready_i = 4'b0000; cyc();
    arready_i = 4'b0001; cyc();
    arready_i = 4'b0000;
    set_ar(32'h1000_0040, 16'h2, 8'd1, 6'h02); cyc();
    arvalid_i = 0; repeat (3) cyc();
    outstanding_trans_i = 0; cyc(); cyc();
    arready_i = 4'b0100; cyc();
    arready_i = 4'b0000; cyc();
    // full counter gates acceptance
    full_counter_i = 1; set_ar(32'h0000_0200, 16'h3, 8'd2, 6'h03); repeat (3) cyc();
    full_counter_i = 0; cyc();
    arvalid_i = 0; arready_i = 4'b0001; cyc();
    arready_i = 4'b0000; cyc();
    // overlap priority and disabled region
    regions_off();
    s_a[1] = 32'h5000; e_a[1] = 32'h5FFF; s_a[3] = 32'h4000; e_a[3] = 32'h6FFF;
    enable_region_i = 4'b1010;
    set_ar(32'h5500, 16'h7, 8'd4, 6'h07); cyc();
    arvalid_i = 0; cyc();
    chk("tp5_overlap", arvalid_o, 4'b0010);
    arready_i = 4'b0010; cyc();
    arready_i = 4'b0000; enable_region_i = 4'b1000;
    set_ar(32'h5500, 16'h8, 8'd5, 6'h08); cyc();
    arvalid_i = 0; cyc();
    chk("tp5_disabled", arvalid_o, 4'b1000);
    // reset while forwarding
    rst_n = 0; cyc();
    chk("tp6_valid", arvalid_o, 4'b0000);
    rst_n = 1; cyc();
    // random traffic
    for (int c = 0; c < 4000; c++) begin
      if (c % 50 == 0) begin
        for (int k = 0; k < N; k++) begin
          s_a[k] = $urandom_range(0, 1023);
          e_a[k] = ($urandom_range(0, 9) == 0) ? s_a[k] - 1 : s_a[k] + $urandom_range(0, 400);
        end
        enable_region_i = N'($urandom);
      end
      rst_n = ($urandom_range(0, 99) != 0);
      araddr_i = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 1500);
      arid_i = IDW'($urandom); arlen_i = 8'($urandom); aruser_i = UW'($urandom);
      arvalid_i = $urandom_range(0, 1);
      arready_i = N'($urandom);
      full_counter_i = ($urandom_range(0, 4) == 0);
      outstanding_trans_i = $urandom_range(0, 1);
      error_gnt_i = ($urandom_range(0, 2) == 0);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/axi_ar_route_decoder.md
Name: axi_ar_route_decoder

Overview:
- Per-target-port read-address stage sitting directly upstream of the read-response allocator.
- Accepts one AR request from its master and decodes the address against N_INIT_PORT address ranges. A hit forwards the request to exactly one initiator port. A miss triggers a DECERR read response through the allocator's error handshake.
- Drives the allocator's outstanding-transaction increment and error-info sampling strobes. Obeys the allocator's full and outstanding indications.

Parameters:
- N_INIT_PORT, 4, number of initiator (slave-side) ports; must be ≥1.
- AXI_ADDR_W, 32, address width.
- AXI_ID_IN, 16, incoming ID width.
- AXI_USER_W, 6, user width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- araddr_i  in  AXI_ADDR_W  request address
- arid_i  in  AXI_ID_IN  request ID
- arlen_i  in  8  burst length minus 1
- aruser_i  in  AXI_USER_W  request user
- arvalid_i  in  1  request valid
- arready_o  out  1  request accepted
- start_addr_i  in  N_INIT_PORT×AXI_ADDR_W  region base per initiator port, inclusive
- end_addr_i  in  N_INIT_PORT×AXI_ADDR_W  region end per initiator port, inclusive
- enable_region_i  in  N_INIT_PORT  region enable
- araddr_o  out  AXI_ADDR_W  forwarded address, shared by all ports
- arid_o  out  AXI_ID_IN  forwarded ID
- arlen_o  out  8  forwarded length
- aruser_o  out  AXI_USER_W  forwarded user
- arvalid_o  out  N_INIT_PORT  one-hot per-port valid
- arready_i  in  N_INIT_PORT  per-port ready
- incr_req_o  out  1  one-cycle pulse per forwarded AR handshake
- full_counter_i  in  1  allocator outstanding counter saturated
- outstanding_trans_i  in  1  allocator has pending bursts
- error_req_o  out  1  DECERR request to allocator
- error_gnt_i  in  1  allocator finished the error response
- error_len_o  out  8  error burst length minus 1
- error_id_o  out  AXI_ID_IN  error ID
- error_user_o  out  AXI_USER_W  error user
- sample_ardata_info_o  out  1  one-cycle strobe: allocator latches error info

Behaviour:
- Reset is synchronous and active-low on rst_n, sampled at the rising edge of clk. rst_n=0 returns all state to reset values on the next edge, including mid-burst or mid-error.
- Output reset values:
  - state = IDLE.
  - arvalid_o, error_req_o, incr_req_o and sample_ardata_info_o = 0.
  - Registered araddr/arid/arlen/aruser and the error fields = 0.
  - arready_o = 0 while rst_n=0.
- Decode:
  - hit[k] = enable_region_i[k] & (araddr_i ≥ start_addr_i[k]) & (araddr_i ≤ end_addr_i[k]), unsigned.
  - Several hits: lowest index wins.
  - No hits: miss.
- arready_o = (state==IDLE) & ~full_counter_i. Combinational; must not depend on arvalid_i.
- Acceptance (arvalid_i & arready_o) latches addr/id/len/user and the destination index into registers.
- FSM states: IDLE, FWD, DRAIN, ERR.
- IDLE, on acceptance:
  - Hit, and (the destination equals the last forwarded destination, or outstanding_trans_i=0): go to FWD.
  - Hit otherwise: go to DRAIN.
  - Miss: go to ERR, and pulse sample_ardata_info_o in the same cycle as acceptance.
- FWD:
  - arvalid_o[dest]=1 with the registered payload, held stable until arready_i[dest]=1.
  - On the handshake cycle: incr_req_o=1, the last-destination register is updated, go to IDLE.
  - Latency from accept to arvalid_o is 1 cycle. Throughput is at most 1 AR per 2 cycles.
- DRAIN:
  - arvalid_o=0. Stay until outstanding_trans_i=0, then go to FWD.
  - This guarantees in-order responses across initiator ports without ID remapping.
- ERR:
  - error_req_o=1, with error_len/id/user held from the registered request.
  - No forwarding and no acceptance.
  - Go to IDLE on the cycle error_gnt_i=1. No incr_req_o for error bursts.
  - The allocator itself waits for outstanding bursts to drain before answering.
- Last-destination register resets to 0. A hit to port 0 after reset therefore never drains.
- full_counter_i only gates acceptance in IDLE. Requests already in FWD still complete, because the allocator saturates its counter.
- error_gnt_i or arready_i asserted outside the matching state is ignored.
- Payload for error uses arlen exactly; arlen=0 produces a single-beat error response.

Optional Feature:
- Macro AXI_AR_DEST_LOCK_EN.
- Defined: DRAIN behaviour exactly as above.
- Undefined:
  - DRAIN is never entered; a hit always goes IDLE→FWD.
  - The last-destination register is removed.
  - The system must then guarantee distinct IDs per destination.

Test Plan:
- Region0=0x0000_0000–0x0FFF_FFFF enabled; AR addr 0x0000_1000, id 0x5, len 3 → arvalid_o=4'b0001 one cycle after accept, payload matches, incr_req_o pulses once on arready_i[0].
- Addr 0x8000_0000, no region hit, len 7, id 0x9 → sample_ardata_info_o pulse on accept; error_req_o high with len 7, id 0x9 until error_gnt_i; then arready_o=1 again, incr_req_o never pulses.
- Forward to port 0 with outstanding_trans_i=1, then request to port 2 → arvalid_o stays 0 until outstanding_trans_i drops, then 4'b0100 next cycle. Without AXI_AR_DEST_LOCK_EN → 4'b0100 immediately.
- full_counter_i=1 with arvalid_i=1 → arready_o=0, no state change; full_counter_i drops → accept in that cycle.
- Overlapping regions 1 and 3 both hit → arvalid_o=4'b0010. Disabled region 1 → 4'b1000.
- rst_n=0 asserted in FWD with arready_i low → next edge: arvalid_o=0, state IDLE, arready_o=1 after release.
